// File: rtl/btn_pkg.sv
// ============================================================================
// Module      : btn_pkg
// Description : Shared button channel indices and default timing constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;

  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;

  localparam int NUM_BTNS_DEF         = 4;
  localparam int DEBOUNCE_CYCLES_10MS = 1000000;
  localparam int REPEAT_DELAY_DEF     = 50000000;
  localparam int REPEAT_PERIOD_DEF    = 10000000;

  localparam logic [NUM_BTNS_DEF-1:0] REPEAT_MASK_DEF =
    NUM_BTNS_DEF'((1 << BTN_UP) | (1 << BTN_DOWN));

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_cell.sv
// ============================================================================
// Module      : debounce_cell
// Description : One button channel: 2-flop synchroniser, debounce counter,
//               stable level and press pulse; auto-repeat with BTN_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_cell
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MS,
`ifdef BTN_AUTOREPEAT_EN
  parameter bit REP_EN        = 1'b0,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
`endif
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_pulse,
  output logic o_level
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  logic w_diff;
  logic w_done;
  logic w_rise;
  logic w_rep_fire;

  assign w_diff = r_s2 ^ r_stable;
  assign w_done = w_diff && (r_cnt == c_last);
  assign w_rise = w_done && r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_pulse <= w_rise | w_rep_fire;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt    <= '0;
        r_stable <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  if (REP_EN) begin : g_rep
    localparam int REP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_first;

    // Counter holds cycles since the last emitted pulse; the first gap is longer.
    assign w_rep_fire = r_stable && !w_done &&
                        (r_rep_cnt == (r_rep_first ? REP_W'(REPEAT_DELAY)
                                                   : REP_W'(REPEAT_PERIOD)));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b0;
      end else if (w_rise) begin
        r_rep_cnt   <= REP_W'(1);
        r_rep_first <= 1'b1;
      end else if (!r_stable || w_done) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b0;
      end else if (w_rep_fire) begin
        r_rep_cnt   <= REP_W'(1);
        r_rep_first <= 1'b0;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end else begin : g_no_rep
    assign w_rep_fire = 1'b0;
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  assign o_pulse = r_pulse;
  assign o_level = r_stable;

endmodule

`default_nettype wire

// File: rtl/button_pulse_gen.sv
// ============================================================================
// Module      : button_pulse_gen
// Description : Debounced single-cycle press pulses for the counter's buttons;
//               optional auto-repeat enabled by defining BTN_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_pulse_gen
  import btn_pkg::*;
#(
  parameter int                    NUM_BTNS        = NUM_BTNS_DEF,
  parameter int                    DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MS,
  parameter int                    CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int                    REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int                    REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter logic [NUM_BTNS-1:0]   REPEAT_MASK     = NUM_BTNS'(REPEAT_MASK_DEF)
) (
  input  logic                Clk100M,
  input  logic                Reset,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_pulse,
  output logic [NUM_BTNS-1:0] btn_level
);

  // Channels are independent; arbitration between buttons happens downstream.
  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef BTN_AUTOREPEAT_EN
      .REP_EN          (REPEAT_MASK[gi]),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
      .CNT_W           (CNT_W)
    ) u_cell (
      .clk     (Clk100M),
      .rst     (Reset),
      .i_raw   (btn_raw[gi]),
      .o_pulse (btn_pulse[gi]),
      .o_level (btn_level[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_button_pulse_gen.sv
// ============================================================================
// Module      : tb_button_pulse_gen
// Description : Directed self-checking bench for button_pulse_gen
//               (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_pulse_gen;

  localparam int NB = 4;

  logic          clk;
  logic          rst;
  logic [NB-1:0] raw;
  logic [NB-1:0] pulse;
  logic [NB-1:0] level;

  int n_checks = 0;
  int n_errors = 0;

  button_pulse_gen #(
    .NUM_BTNS        (NB),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .Clk100M   (clk),
    .Reset     (rst),
    .btn_raw   (raw),
    .btn_pulse (pulse),
    .btn_level (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    raw = '0;
    tick(3);
    chk("reset_level", level, 4'b0000);
    chk("reset_pulse", pulse, 4'b0000);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_clean_press();
    logic [NB-1:0] seen;
    raw[2] = 1'b1;
    tick(5);
    chk("press_before_latency", {level[2], pulse[2], 2'b00}, 4'b0000);
    tick(1);
    chk("press_level", level, 4'b0100);
    chk("press_pulse", pulse, 4'b0100);
    tick(1);
    chk("press_pulse_one_cycle", pulse, 4'b0000);
    seen = '0;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      seen |= pulse;
    end
    chk("held_no_repeat", seen, 4'b0000);
    raw[2] = 1'b0;
    tick(5);
    chk("release_level_held", level, 4'b0100);
    tick(1);
    chk("release_level_fall", level, 4'b0000);
    chk("release_no_pulse", pulse, 4'b0000);
    tick(3);
  endtask

  task automatic test_bounce();
    logic [NB-1:0] seen;
    seen = '0;
    raw[0] = 1'b1; tick(1); seen |= pulse | level;
    raw[0] = 1'b0; tick(1); seen |= pulse | level;
    raw[0] = 1'b1; tick(1); seen |= pulse | level;
    raw[0] = 1'b0; tick(1); seen |= pulse | level;
    raw[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      seen |= pulse | level;
    end
    chk("bounce_quiet", seen, 4'b0000);
    tick(1);
    chk("bounce_pulse", pulse, 4'b0001);
    tick(1);
    chk("bounce_single", pulse, 4'b0000);
    raw[0] = 1'b0;
    tick(8);
    chk("bounce_released", level, 4'b0000);
  endtask

  task automatic test_glitch();
    logic [NB-1:0] seen;
    seen = '0;
    raw[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      seen |= pulse | level;
    end
    raw[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen |= pulse | level;
    end
    chk("glitch_rejected", seen, 4'b0000);
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] seen;
    raw[3:2] = 2'b11;
    tick(5);
    chk("simul_before", pulse, 4'b0000);
    tick(1);
    chk("simul_pulse", pulse, 4'b1100);
    chk("simul_level", level, 4'b1100);
    raw[3:2] = 2'b00;
    seen = '0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      seen |= pulse;
    end
    chk("simul_release_held", level, 4'b1100);
    tick(1);
    seen |= pulse;
    chk("simul_release_level", level, 4'b0000);
    chk("simul_release_no_pulse", seen, 4'b0000);
    tick(3);
  endtask

  task automatic test_reset_mid();
    raw[2] = 1'b1;
    tick(8);
    chk("pre_reset_level", level, 4'b0100);
    raw[0] = 1'b1;
    tick(3);
    #3;
    rst = 1'b1;
    #1;
    chk("reset_async_level", level, 4'b0000);
    chk("reset_async_pulse", pulse, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(5);
    chk("post_reset_wait", pulse | level, 4'b0000);
    tick(1);
    chk("post_reset_pulse", pulse, 4'b0101);
    tick(1);
    chk("post_reset_single", pulse, 4'b0000);
    chk("post_reset_level", level, 4'b0101);
    raw = '0;
    tick(8);
  endtask

`ifdef BTN_AUTOREPEAT_EN
  task automatic test_autorepeat();
    logic [19:0] trace;
    logic [19:0] seen0;
    raw[3] = 1'b1;
    tick(6);
    trace = '0;
    for (int i = 0; i < 20; i++) begin
      trace[i] = pulse[3];
      if (i < 19) tick(1);
    end
    n_checks++;
    if (trace !== 20'b0001_0010_0100_0000_0001) begin
      n_errors++;
      $display("FAIL autorepeat_trace: got %b expected %b", trace, 20'b0001_0010_0100_0000_0001);
    end
    raw[3] = 1'b0;
    tick(8);
    raw[0] = 1'b1;
    tick(6);
    seen0 = '0;
    for (int i = 0; i < 20; i++) begin
      seen0[i] = pulse[0];
      tick(1);
    end
    n_checks++;
    if (seen0 !== 20'b0000_0000_0000_0000_0001) begin
      n_errors++;
      $display("FAIL masked_trace: got %b expected %b", seen0, 20'b0000_0000_0000_0000_0001);
    end
    raw[0] = 1'b0;
    tick(8);
  endtask
`endif

  initial begin
    rst = 1'b0;
    raw = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
`ifdef BTN_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
